// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: fixed-point format, node degrees and the
// variable-node FSM state encoding.
package ldpc_pkg;

    localparam int INT    = 8;
    localparam int FRAC   = 8;
    localparam int W      = INT + FRAC;
    localparam int VN_DEG = 3;
    localparam int CN_DEG = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_EMIT = 2'd2
    } vn_state_e;

endpackage

// File: rtl/sat_fx.sv
// Two's-complement saturation of a wide value down to W bits.
module sat_fx #(
    parameter int IW = 20,
    parameter int W  = 16
) (
    input  logic signed [IW-1:0] din,
    output logic        [W-1:0]  dout
);

    // Pass through when all bits above the W-bit sign agree, else clamp.
    always_comb begin
        dout = din[W-1:0];
        if (din[IW-1:W-1] == {(IW-W+1){din[IW-1]}}) begin
            dout = din[W-1:0];
        end else if (din[IW-1]) begin
            dout = {1'b1, {(W-1){1'b0}}};
        end else begin
            dout = {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/vn_serial.sv
// Serial LDPC variable node: accumulates the channel LLR and DEG check messages,
// then emits DEG extrinsic messages (total minus own edge) to the check nodes.
module vn_serial #(
    parameter int INT = ldpc_pkg::INT,
    parameter int FRAC = ldpc_pkg::FRAC,
    parameter int DEG = ldpc_pkg::VN_DEG,
    localparam int W  = INT + FRAC,
    localparam int CW = (DEG > 1) ? $clog2(DEG) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  llr_in,
    input  logic [W-1:0]  msg_in,
    input  logic          msg_in_valid,
    output logic          msg_in_ready,
    output logic [W-1:0]  msg_out,
    output logic          msg_out_valid,
    input  logic          msg_out_ready,
    output logic [CW-1:0] msg_out_idx,
    output logic          hard_dec,
    output logic          dec_valid,
    output logic          busy
);

    localparam int AW = W + $clog2(DEG + 1);
    localparam int DW = AW + 1;

    ldpc_pkg::vn_state_e state_r, state_nxt_s;
    logic [CW-1:0]       cnt_r, cnt_nxt_s, idx_r, idx_nxt_s;
    logic signed [AW-1:0] acc_r, acc_nxt_s;
    logic [W-1:0]        llr_r, llr_nxt_s;
    logic [W-1:0]        stored_r [DEG];
    logic [W-1:0]        stored_nxt_s [DEG];
    logic                dec_load_s;
    logic signed [DW-1:0] total_nxt_s, diff_s;
    logic [W-1:0]        sat_s;

    // Next-state, datapath update and handshake decisions.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        idx_nxt_s    = idx_r;
        acc_nxt_s    = acc_r;
        llr_nxt_s    = llr_r;
        stored_nxt_s = stored_r;
        dec_load_s   = 1'b0;
        case (state_r)
            ldpc_pkg::ST_IDLE: begin
                if (start) begin
                    llr_nxt_s   = llr_in;
                    acc_nxt_s   = {AW{1'b0}};
                    cnt_nxt_s   = {CW{1'b0}};
                    idx_nxt_s   = {CW{1'b0}};
                    state_nxt_s = ldpc_pkg::ST_ACC;
                end else begin
                    state_nxt_s = ldpc_pkg::ST_IDLE;
                end
            end
            ldpc_pkg::ST_ACC: begin
                if (msg_in_valid) begin
                    stored_nxt_s[cnt_r] = msg_in;
                    acc_nxt_s = acc_r + AW'($signed(msg_in));
                    if (cnt_r == CW'(DEG - 1)) begin
                        cnt_nxt_s   = {CW{1'b0}};
                        idx_nxt_s   = {CW{1'b0}};
                        dec_load_s  = 1'b1;
                        state_nxt_s = ldpc_pkg::ST_EMIT;
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end else begin
                    state_nxt_s = ldpc_pkg::ST_ACC;
                end
            end
            ldpc_pkg::ST_EMIT: begin
                if (msg_out_ready) begin
                    if (idx_r == CW'(DEG - 1)) begin
                        idx_nxt_s   = {CW{1'b0}};
                        state_nxt_s = ldpc_pkg::ST_IDLE;
                    end else begin
                        idx_nxt_s = idx_r + CW'(1);
                    end
                end else begin
                    state_nxt_s = ldpc_pkg::ST_EMIT;
                end
            end
            default: begin
                state_nxt_s = ldpc_pkg::ST_IDLE;
            end
        endcase
    end

    // Outputs are registered, so they are computed from next-cycle values;
    // the difference is formed wide enough that it can never wrap.
    always_comb begin
        total_nxt_s = DW'($signed(llr_nxt_s)) + DW'(acc_nxt_s);
        diff_s      = total_nxt_s - DW'($signed(stored_nxt_s[idx_nxt_s]));
    end

    sat_fx #(
        .IW (DW),
        .W  (W)
    ) u_sat (
        .din  (diff_s),
        .dout (sat_s)
    );

    // State, datapath and registered output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ldpc_pkg::ST_IDLE;
            cnt_r         <= {CW{1'b0}};
            idx_r         <= {CW{1'b0}};
            acc_r         <= {AW{1'b0}};
            llr_r         <= {W{1'b0}};
            for (int i = 0; i < DEG; i++) begin
                stored_r[i] <= {W{1'b0}};
            end
            msg_in_ready  <= 1'b0;
            msg_out_valid <= 1'b0;
            msg_out       <= {W{1'b0}};
            msg_out_idx   <= {CW{1'b0}};
            hard_dec      <= 1'b0;
            dec_valid     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            idx_r         <= idx_nxt_s;
            acc_r         <= acc_nxt_s;
            llr_r         <= llr_nxt_s;
            stored_r      <= stored_nxt_s;
            msg_in_ready  <= (state_nxt_s == ldpc_pkg::ST_ACC);
            msg_out_valid <= (state_nxt_s == ldpc_pkg::ST_EMIT);
            busy          <= (state_nxt_s != ldpc_pkg::ST_IDLE);
            msg_out       <= sat_s;
            msg_out_idx   <= idx_nxt_s;
            dec_valid     <= dec_load_s;
            if (dec_load_s) begin
                hard_dec <= total_nxt_s[DW-1];
            end else begin
                hard_dec <= hard_dec;
            end
        end
    end

endmodule
